muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
- Iterative multiply/divide unit with HI/LO registers for MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Sits directly downstream of the register file: operand_a is driven by Data1 (rs) and operand_b by Data2 (rt).
- Stalls the pipeline through busy.
- hi/lo are read by MFHI/MFLO and routed through the writeback mux into WriteData.

Parameters:
- WIDTH, 32, operand/HI/LO width; only 32 is supported and verified.
- CNT_W, 5, iteration counter width; must equal log2(WIDTH).

Ports:
- clock  in  1  rising-edge clock shared with the register file.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request strobe; sampled only in IDLE.
- op  in  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6-7 reserved.
- operand_a  in  32  rs value (Data1): multiplicand, dividend, or MTHI/MTLO source.
- operand_b  in  32  rt value (Data2): multiplier or divisor.
- busy  out  1  high while an arithmetic op is in flight.
- done  out  1  one-cycle pulse in the first cycle new HI/LO are visible.
- hi  out  32  HI register.
- lo  out  32  LO register.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - state=IDLE, counter=0.
  - hi=0, lo=0, busy=0, done=0.
  - Any in-flight op is discarded; no done pulse follows.
- States:
  - IDLE: waits for start.
  - CALC: 32 iterations, one bit per clock.
  - FIX: sign correction and HI/LO write.
  - IDLE again after FIX.
- IDLE with start=1 and op 0-3, at edge E0:
  - latch |a| and |b| (signed ops) or raw values (unsigned ops);
  - latch result-sign flags;
  - counter=31; go to CALC.
- CALC:
  - each edge performs one step; counter decrements.
  - at counter==0, go to FIX. This is edges E1..E32.
  - Multiply step: shift-add into a 64-bit accumulator.
  - Divide step: restoring shift-subtract; remainder in the upper half, quotient in the lower half.
- FIX, at edge E33:
  - apply sign correction; write hi/lo; go to IDLE.
  - done=1 for exactly the cycle after E33.
- busy:
  - registered; 1 from after E0 through E33, i.e. 33 cycles.
  - 0 in the cycle done is high.
  - hi/lo hold their old values until E33.
- start in any state other than IDLE is ignored; no queuing. The pipeline must hold start while busy.
- MTHI/MTLO, start in IDLE with op 4 or 5:
  - hi (or lo) = operand_a at that edge.
  - busy stays 0; no done pulse.
- Reserved op 6-7 with start: no effect; stays IDLE.
- Multiply results:
  - {hi,lo} is the full 64-bit product.
  - Signed: product negated (two's complement, 64-bit) when operand signs differ.
- Divide results:
  - lo = quotient, truncated toward zero; hi = remainder.
  - Remainder takes the sign of the dividend.
  - Quotient negated when signs differ.
- Divide by zero (operand_b==0, DIV or DIVU):
  - still takes the full 34-cycle path.
  - lo=0xFFFFFFFF, hi=operand_a.
- Signed overflow (0x80000000 / 0xFFFFFFFF): lo=0x80000000, hi=0 (natural 32-bit wrap).
- Operand inputs are don't-care after E0; all state is internally latched.
- Each arithmetic op starts one edge after done at the earliest. A start while done=1 is accepted normally, since state is IDLE.

Decomposition:
- Shared package mips_muldiv_pkg holds:
  - op encodings (OP_MULT..OP_MTLO);
  - state encoding (IDLE, CALC, FIX);
  - WIDTH/CNT_W constants.
  These are shared with the control unit that generates op.
- One sub-module is natural: muldiv_step.
  - Combinational single iteration for both multiply and divide.
  - Takes a 64-bit accumulator, the 32-bit operand and a mode bit; returns the next accumulator.
- muldiv_unit keeps the FSM, counter, sign handling and HI/LO.

Test Plan:
- Reset, then MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> busy high 33 cycles; done pulse 34 cycles after the start edge; hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=5, b=0xFFFFFFF6 (-10) -> hi=0xFFFFFFFF, lo=0xFFFFFFCE (-50). DIVU a=10, b=5 -> lo=2, hi=0.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=5, b=0 -> lo=0xFFFFFFFF, hi=5 after the full latency. DIV a=0xFFFFFFF9, b=0 -> lo=0xFFFFFFFF, hi=0xFFFFFFF9.
- MTHI a=0x1234 in IDLE -> hi=0x1234 next cycle, busy stays 0, no done. MULTU 3*4 followed by start MULT 7*7 at cycle 5 -> second request ignored; hi=0, lo=12.
- MULTU 3*4, assert reset asynchronously (off clock edge) at cycle 10 -> busy, done, hi, lo go to 0 immediately; no done pulse over the next 40 cycles. A new DIVU 9/2 afterwards -> lo=4, hi=1.

Source files
------------

// File: rtl/mips_muldiv_pkg.sv
// mips_muldiv_pkg: op/state encodings and widths shared by the mul/div unit and the control unit
package mips_muldiv_pkg;
   localparam int WIDTH = 32;
   localparam int CNT_W = 5;
   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] FIX  = 2'd2;
   function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v, input logic sgn);
      return (sgn && v[WIDTH-1]) ? -v : v;
   endfunction
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational multiply (shift-add) or divide (restoring) iteration
module muldiv_step
   import mips_muldiv_pkg::*;
(
   input  logic [2*WIDTH-1:0] acc_i,
   input  logic [WIDTH-1:0]   opnd_i,
   input  logic               div_i,
   output logic [2*WIDTH-1:0] acc_o
);
   logic [WIDTH:0] sum;
   logic [WIDTH:0] rem;
   logic [WIDTH:0] diff;
   // multiply adds into the upper half and shifts right; divide shifts left and trial-subtracts
   always_comb begin
      sum   = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
      rem   = acc_i[2*WIDTH-1:WIDTH-1];
      diff  = rem - {1'b0, opnd_i};
      acc_o = !div_i ? {sum, acc_i[WIDTH-1:1]} :
              (rem >= {1'b0, opnd_i}) ? {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1} :
              {acc_i[2*WIDTH-2:0], 1'b0};
   end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU with HI/LO registers and MTHI/MTLO
module muldiv_unit
   import mips_muldiv_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   logic [1:0]         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d, acc_step, prod;
   logic [WIDTH-1:0]   opnd_q, opnd_d, hi_q, hi_d, lo_q, lo_d, a_abs, b_abs;
   logic               div_q, div_d, neg_q, neg_d, rneg_q, rneg_d;
   logic               busy_q, busy_d, done_q, done_d, sgn;

   muldiv_step u_step (.acc_i(acc_q), .opnd_i(opnd_q), .div_i(div_q), .acc_o(acc_step));

   // next-state: operand latch in IDLE, one step per CALC cycle, sign fix and HI/LO write in FIX
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      opnd_d  = opnd_q;
      div_d   = div_q;
      neg_d   = neg_q;
      rneg_d  = rneg_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      sgn     = ~op[0];
      a_abs   = abs_val(operand_a, sgn);
      b_abs   = abs_val(operand_b, sgn);
      prod    = neg_q ? -acc_q : acc_q;
      if (state_q == IDLE && start && op <= OP_DIVU) begin
         div_d   = op[1];
         acc_d   = {{WIDTH{1'b0}}, op[1] ? a_abs : b_abs};
         opnd_d  = op[1] ? b_abs : a_abs;
         // a zero divisor keeps the all-ones quotient unsigned-looking, so no negation then
         neg_d   = sgn & (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]) & (~op[1] | (|operand_b));
         rneg_d  = sgn & operand_a[WIDTH-1];
         cnt_d   = CNT_W'(WIDTH - 1);
         state_d = CALC;
      end else if (state_q == IDLE && start) begin
         hi_d = (op == OP_MTHI) ? operand_a : hi_q;
         lo_d = (op == OP_MTLO) ? operand_a : lo_q;
      end else if (state_q == CALC) begin
         acc_d   = acc_step;
         cnt_d   = cnt_q - CNT_W'(1);
         state_d = (cnt_q == '0) ? FIX : CALC;
      end else if (state_q == FIX) begin
         hi_d    = !div_q ? prod[2*WIDTH-1:WIDTH] :
                   rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
         lo_d    = !div_q ? prod[WIDTH-1:0] :
                   neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
         state_d = IDLE;
      end
      busy_d = state_d != IDLE;
      done_d = state_q == FIX;
   end

   // state registers with asynchronous clear that also discards any in-flight op
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         opnd_q  <= '0;
         div_q   <= 1'b0;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         opnd_q  <= opnd_d;
         div_q   <= div_d;
         neg_q   <= neg_d;
         rneg_q  <= rneg_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;
endmodule
